// File: rtl/pam_pkg.sv
// PAM-4 slicer shared definitions: symbol type, nominal level codes,
// default slicing thresholds and the binary-to-Gray symbol helper.
// Imported by pam4_slice_lane and pam4_slicer_decoder.
package pam_pkg;

  typedef logic [1:0] pam4_sym_t;

  // Nominal transmit levels (signed sample codes) and their natural symbols
  localparam int LVL_00 = -84;
  localparam int LVL_01 = -28;
  localparam int LVL_10 = 28;
  localparam int LVL_11 = 84;

  // Thresholds sit halfway between adjacent nominal levels
  localparam int THR_LO_DEF  = -56;
  localparam int THR_MID_DEF = 0;
  localparam int THR_HI_DEF  = 56;

  // Ascending levels 00,01,10,11 map to 00,01,11,10
  function automatic pam4_sym_t bin2gray(input pam4_sym_t b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/pam4_slice_lane.sv
// One-lane PAM-4 decision: signed compare against three thresholds plus
// low-margin detect. Purely combinational (zero latency, no backpressure).
// Ports: i_sample / i_thr_lo / i_thr_mid / i_thr_hi (signed RES bits) ->
//        o_sym (2-bit symbol), o_margin_err (|sample - any threshold| < MARGIN).
// Macro PAM4_GRAY_DECODE_EN: when defined, o_sym is Gray-coded.
module pam4_slice_lane
  import pam_pkg::*;
#(
  parameter int RES    = 8,
  parameter int MARGIN = 8
) (
  input  logic [RES-1:0] i_sample,
  input  logic [RES-1:0] i_thr_lo,
  input  logic [RES-1:0] i_thr_mid,
  input  logic [RES-1:0] i_thr_hi,
  output logic [1:0]     o_sym,
  output logic           o_margin_err
);

  localparam logic [RES:0] MARGIN_V = (RES+1)'(MARGIN);

  // Distance computed one bit wider than the samples so that e.g.
  // 127 - (-128) cannot wrap.
  function automatic logic near_thr(input logic [RES-1:0] s, input logic [RES-1:0] t);
    logic [RES:0] d;
    logic [RES:0] a;
    d = {s[RES-1], s} - {t[RES-1], t};
    a = d[RES] ? (~d + 1'b1) : d;
    return (a < MARGIN_V);
  endfunction

  pam4_sym_t w_sym_bin;

  // First true comparison wins, so misordered thresholds still give a
  // deterministic answer; equality falls through to the upper symbol.
  always_comb begin
    w_sym_bin = 2'b11;
    if ($signed(i_sample) < $signed(i_thr_lo))
      w_sym_bin = 2'b00;
    else if ($signed(i_sample) < $signed(i_thr_mid))
      w_sym_bin = 2'b01;
    else if ($signed(i_sample) < $signed(i_thr_hi))
      w_sym_bin = 2'b10;
  end

`ifdef PAM4_GRAY_DECODE_EN
  assign o_sym = bin2gray(w_sym_bin);
`else
  assign o_sym = w_sym_bin;
`endif

  assign o_margin_err = near_thr(i_sample, i_thr_lo)
                      | near_thr(i_sample, i_thr_mid)
                      | near_thr(i_sample, i_thr_hi);

endmodule

// File: rtl/pam4_slicer_decoder.sv
// Multi-lane PAM-4 slicer: samples -> 2-bit symbols with per-lane low-margin flags/counters.
// Latency: 2 cycles (S1 captures samples+thresholds, S2 captures decisions).
// Backpressure: valid/ready; each stage advances when empty or when the next one advances.
// Ports: voltage_level_in[_valid/_ready] (lane i at [i*RES +: RES]), thr_lo/mid/hi,
//        symbol_out (lane i at [2i+1:2i]) + margin_err_out + symbol_out_valid/_ready,
//        err_clr (sync clear), margin_err_cnt (lane i at [i*CNT_WIDTH +: CNT_WIDTH]).
// Macro PAM4_GRAY_DECODE_EN: Gray-coded symbol_out when defined, natural binary otherwise.
module pam4_slicer_decoder
  import pam_pkg::*;
#(
  parameter int NUM_LANES         = 2,
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int MARGIN            = 8,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_LANES*SIGNAL_RESOLUTION-1:0] voltage_level_in,
  input  logic                                   voltage_level_in_valid,
  output logic                                   voltage_level_in_ready,
  input  logic [SIGNAL_RESOLUTION-1:0]           thr_lo,
  input  logic [SIGNAL_RESOLUTION-1:0]           thr_mid,
  input  logic [SIGNAL_RESOLUTION-1:0]           thr_hi,
  output logic [2*NUM_LANES-1:0]                 symbol_out,
  output logic [NUM_LANES-1:0]                   margin_err_out,
  output logic                                   symbol_out_valid,
  input  logic                                   symbol_out_ready,
  input  logic                                   err_clr,
  output logic [NUM_LANES*CNT_WIDTH-1:0]         margin_err_cnt
);

  localparam int RES = SIGNAL_RESOLUTION;

  // Stage 1: raw samples plus the thresholds in force when the beat was accepted
  logic                     r_s1_valid;
  logic [NUM_LANES*RES-1:0] r_s1_samples;
  logic [RES-1:0]           r_s1_thr_lo;
  logic [RES-1:0]           r_s1_thr_mid;
  logic [RES-1:0]           r_s1_thr_hi;

  // Stage 2: decisions presented to the downstream
  logic                     r_s2_valid;
  logic [2*NUM_LANES-1:0]   r_s2_sym;
  logic [NUM_LANES-1:0]     r_s2_flag;

  logic [CNT_WIDTH-1:0]     r_cnt [NUM_LANES];

  logic                     w_s2_ready;
  logic                     w_s1_ready;
  logic                     w_out_xfer;
  logic [2*NUM_LANES-1:0]   w_sym;
  logic [NUM_LANES-1:0]     w_flag;

  assign w_s2_ready             = !r_s2_valid || symbol_out_ready;
  assign w_s1_ready             = !r_s1_valid || w_s2_ready;
  assign w_out_xfer             = r_s2_valid && symbol_out_ready;
  assign voltage_level_in_ready = w_s1_ready;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      pam4_slice_lane #(
        .RES    (RES),
        .MARGIN (MARGIN)
      ) u_slice (
        .i_sample     (r_s1_samples[g*RES +: RES]),
        .i_thr_lo     (r_s1_thr_lo),
        .i_thr_mid    (r_s1_thr_mid),
        .i_thr_hi     (r_s1_thr_hi),
        .o_sym        (w_sym[2*g +: 2]),
        .o_margin_err (w_flag[g])
      );
      assign margin_err_cnt[g*CNT_WIDTH +: CNT_WIDTH] = r_cnt[g];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_samples <= '0;
      r_s1_thr_lo  <= '0;
      r_s1_thr_mid <= '0;
      r_s1_thr_hi  <= '0;
    end else if (w_s1_ready) begin
      r_s1_valid <= voltage_level_in_valid;
      if (voltage_level_in_valid) begin
        r_s1_samples <= voltage_level_in;
        r_s1_thr_lo  <= thr_lo;
        r_s1_thr_mid <= thr_mid;
        r_s1_thr_hi  <= thr_hi;
      end
    end
  end

  // Data only reloads when S2 can move, so outputs hold while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_sym   <= '0;
      r_s2_flag  <= '0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sym  <= w_sym;
        r_s2_flag <= w_flag;
      end
    end
  end

  // Clear wins over a coincident flagged transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LANES; i++) r_cnt[i] <= '0;
    end else if (err_clr) begin
      for (int i = 0; i < NUM_LANES; i++) r_cnt[i] <= '0;
    end else if (w_out_xfer) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (r_s2_flag[i] && (r_cnt[i] != {CNT_WIDTH{1'b1}}))
          r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
      end
    end
  end

  assign symbol_out       = r_s2_sym;
  assign margin_err_out   = r_s2_flag;
  assign symbol_out_valid = r_s2_valid;

endmodule

// File: tb/tb_pam4_slicer_decoder.sv
module tb_pam4_slicer_decoder;

  localparam int MRG = 8;
  localparam int CMAX = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] vin;
  logic        in_vld;
  logic        in_rdy;
  logic [7:0]  thr_lo, thr_mid, thr_hi;
  logic [3:0]  sym;
  logic [1:0]  merr;
  logic        out_vld;
  logic        out_rdy;
  logic        err_clr;
  logic [7:0]  cnt_bus;

  int n_checks = 0;
  int n_pass   = 0;

  // Observations of the most recent driven cycle
  logic       obs_rdy, obs_vld, obs_acc, obs_xfer;
  logic [3:0] obs_sym;
  logic [1:0] obs_flag;
  logic [7:0] obs_cnt;
  logic [5:0] exp_beat;              // {flag1, flag0, sym1, sym0}
  logic [5:0] exp_q[$];
  int         mcnt[2];

  pam4_slicer_decoder #(
    .NUM_LANES(2), .SIGNAL_RESOLUTION(8), .MARGIN(MRG), .CNT_WIDTH(4)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .voltage_level_in       (vin),
    .voltage_level_in_valid (in_vld),
    .voltage_level_in_ready (in_rdy),
    .thr_lo                 (thr_lo),
    .thr_mid                (thr_mid),
    .thr_hi                 (thr_hi),
    .symbol_out             (sym),
    .margin_err_out         (merr),
    .symbol_out_valid       (out_vld),
    .symbol_out_ready       (out_rdy),
    .err_clr                (err_clr),
    .margin_err_cnt         (cnt_bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Level index 0..3 -> symbol code on the wire
  function automatic int enc(input int lvl);
`ifdef PAM4_GRAY_DECODE_EN
    case (lvl)
      0: return 0;
      1: return 1;
      2: return 3;
      default: return 2;
    endcase
`else
    return lvl;
`endif
  endfunction

  // {flag, sym[1:0]} for one sample against the current thresholds
  function automatic logic [2:0] ref_lane(input logic [7:0] smp);
    int s, lo, mi, hi, lvl;
    logic f;
    logic [1:0] c;
    s  = $signed(smp);
    lo = $signed(thr_lo);
    mi = $signed(thr_mid);
    hi = $signed(thr_hi);
    if (s < lo)      lvl = 0;
    else if (s < mi) lvl = 1;
    else if (s < hi) lvl = 2;
    else             lvl = 3;
    f = (iabs(s - lo) < MRG) || (iabs(s - mi) < MRG) || (iabs(s - hi) < MRG);
    c = 2'(enc(lvl));
    return {f, c};
  endfunction

  // One clock: drive at negedge, observe handshake, update model, read counters after posedge
  task automatic drive_cycle(input logic v, input logic [7:0] a, input logic [7:0] b,
                             input logic r, input logic c);
    logic [2:0] l0, l1;
    @(negedge clk);
    in_vld  = v;
    vin     = {b, a};
    out_rdy = r;
    err_clr = c;
    #1;
    obs_rdy  = in_rdy;
    obs_vld  = out_vld;
    obs_sym  = sym;
    obs_flag = merr;
    obs_acc  = v && in_rdy;
    obs_xfer = out_vld && r;
    if (obs_acc) begin
      l0 = ref_lane(a);
      l1 = ref_lane(b);
      exp_q.push_back({l1[2], l0[2], l1[1:0], l0[1:0]});
    end
    if (obs_xfer) begin
      if (exp_q.size() > 0) exp_beat = exp_q.pop_front();
      else                  exp_beat = 'x;
    end
    for (int i = 0; i < 2; i++) begin
      if (c) mcnt[i] = 0;
      else if (obs_xfer && exp_beat[4+i] === 1'b1 && mcnt[i] < CMAX) mcnt[i]++;
    end
    @(posedge clk);
    #1;
    obs_cnt = cnt_bus;
  endtask

  function automatic logic [7:0] nominal(input int k);
    logic [7:0] t[4];
    t = '{8'hAC, 8'hE4, 8'h1C, 8'h54};
    return t[k];
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_vld = 1'b0; vin = '0; out_rdy = 1'b0; err_clr = 1'b0;
    thr_lo = 8'hC8; thr_mid = 8'h00; thr_hi = 8'h38;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (out_vld !== 1'b0) $display("FAIL reset_valid got %b want 0", out_vld); else n_pass++;
    n_checks++; if (sym !== 4'h0) $display("FAIL reset_symbol got %h want 0", sym); else n_pass++;
    n_checks++; if (merr !== 2'b00) $display("FAIL reset_flag got %b want 00", merr); else n_pass++;
    n_checks++; if (cnt_bus !== 8'h00) $display("FAIL reset_cnt got %h want 00", cnt_bus); else n_pass++;
    n_checks++; if (in_rdy !== 1'b1) $display("FAIL reset_ready got %b want 1", in_rdy); else n_pass++;
    rst = 1'b0;
    mcnt[0] = 0; mcnt[1] = 0;
  endtask

  task automatic test_nominal();
    logic [7:0] l1;
    int k;
    k = 0;
    for (int c = 0; c < 7; c++) begin
      l1 = nominal($urandom_range(3));
      if (c < 4) drive_cycle(1'b1, nominal(c), l1, 1'b1, 1'b0);
      else       drive_cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (obs_vld !== (c >= 2 && c <= 5))
        $display("FAIL nominal_latency cycle %0d got valid %b want %b", c, obs_vld, (c >= 2 && c <= 5));
      else n_pass++;
      if (obs_xfer) begin
        n_checks++;
        if (obs_sym[1:0] !== 2'(enc(k)) || obs_flag[0] !== 1'b0)
          $display("FAIL nominal_lane0 beat %0d got sym %b flag %b want %b 0", k, obs_sym[1:0], obs_flag[0], 2'(enc(k)));
        else n_pass++;
        n_checks++;
        if ({obs_flag, obs_sym} !== exp_beat)
          $display("FAIL nominal_model beat %0d got %h want %h", k, {obs_flag, obs_sym}, exp_beat);
        else n_pass++;
        k++;
      end
    end
  endtask

  task automatic test_boundary();
    logic [7:0] smp[7];
    int         lv[7];
    logic       fl[7];
    int k;
    smp = '{8'hC8, 8'hFF, 8'h00, 8'h37, 8'h38, 8'h80, 8'h7F};
    lv  = '{1, 1, 2, 2, 3, 0, 3};
    fl  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    drive_cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
    k = 0;
    for (int c = 0; c < 10; c++) begin
      if (c < 7) drive_cycle(1'b1, smp[c], 8'd100, 1'b1, 1'b0);
      else       drive_cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      if (obs_xfer) begin
        n_checks++;
        if (obs_sym[1:0] !== 2'(enc(lv[k])) || obs_flag[0] !== fl[k])
          $display("FAIL boundary beat %0d got sym %b flag %b want %b %b", k, obs_sym[1:0], obs_flag[0], 2'(enc(lv[k])), fl[k]);
        else n_pass++;
        n_checks++;
        if ({obs_flag, obs_sym} !== exp_beat)
          $display("FAIL boundary_model beat %0d got %h want %h", k, {obs_flag, obs_sym}, exp_beat);
        else n_pass++;
        k++;
      end
    end
    n_checks++; if (k != 7) $display("FAIL boundary_count got %0d want 7", k); else n_pass++;
    // -56, -1, 0, 55, 56 are all within 8 of a threshold
    n_checks++; if (obs_cnt !== 8'h05) $display("FAIL boundary_cnt got %h want 05", obs_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic       pat[4];
    logic [7:0] a, b, prev_sym_flag;
    int sent, recv, rdy_low;
    logic prev_stall;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    sent = 0; recv = 0; rdy_low = 0; prev_stall = 1'b0; prev_sym_flag = '0;
    a = 8'($urandom); b = 8'($urandom);
    for (int c = 0; c < 80 && recv < 8; c++) begin
      drive_cycle(sent < 8, a, b, pat[c % 4], 1'b0);
      if (prev_stall) begin
        n_checks++;
        if (obs_vld !== 1'b1 || {2'b00, obs_flag, obs_sym} !== prev_sym_flag)
          $display("FAIL bp_hold cycle %0d got %b/%h want 1/%h", c, obs_vld, {obs_flag, obs_sym}, prev_sym_flag[5:0]);
        else n_pass++;
      end
      if (obs_rdy === 1'b0) begin
        rdy_low++;
        n_checks++;
        if (!(obs_vld === 1'b1 && pat[c % 4] === 1'b0))
          $display("FAIL bp_ready_drop cycle %0d got valid %b ready_out %b want 1 0", c, obs_vld, pat[c % 4]);
        else n_pass++;
      end
      if (obs_xfer) begin
        n_checks++;
        if ({obs_flag, obs_sym} !== exp_beat)
          $display("FAIL bp_order beat %0d got %h want %h", recv, {obs_flag, obs_sym}, exp_beat);
        else n_pass++;
        recv++;
      end
      prev_stall    = obs_vld && !pat[c % 4];
      prev_sym_flag = {2'b00, obs_flag, obs_sym};
      if (obs_acc) begin
        sent++;
        a = 8'($urandom); b = 8'($urandom);
      end
    end
    n_checks++; if (recv != 8) $display("FAIL bp_drain got %0d beats want 8", recv); else n_pass++;
    n_checks++; if (rdy_low == 0) $display("FAIL bp_ready_never_low got %0d want >0", rdy_low); else n_pass++;
    n_checks++; if (obs_cnt !== {4'(mcnt[1]), 4'(mcnt[0])})
      $display("FAIL bp_cnt got %h want %h", obs_cnt, {4'(mcnt[1]), 4'(mcnt[0])}); else n_pass++;
  endtask

  task automatic test_counter();
    drive_cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
    for (int c = 0; c < 23; c++) drive_cycle(c < 20, 8'h00, 8'h01, 1'b1, 1'b0);
    n_checks++; if (obs_cnt !== 8'hFF) $display("FAIL cnt_saturate got %h want ff", obs_cnt); else n_pass++;
    n_checks++; if (obs_cnt !== {4'(mcnt[1]), 4'(mcnt[0])})
      $display("FAIL cnt_model got %h want %h", obs_cnt, {4'(mcnt[1]), 4'(mcnt[0])}); else n_pass++;
    // Flagged beat parked at the output, then released together with err_clr
    drive_cycle(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    drive_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    drive_cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
    n_checks++; if (obs_xfer !== 1'b1 || obs_flag !== 2'b11)
      $display("FAIL clr_xfer got xfer %b flag %b want 1 11", obs_xfer, obs_flag); else n_pass++;
    n_checks++; if (obs_cnt !== 8'h00) $display("FAIL clr_priority got %h want 00", obs_cnt); else n_pass++;
  endtask

  task automatic test_reset_midstream();
    drive_cycle(1'b1, 8'h00, 8'h38, 1'b1, 1'b0);
    drive_cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    drive_cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    n_checks++; if (obs_cnt !== 8'h11) $display("FAIL pre_rst_cnt got %h want 11", obs_cnt); else n_pass++;
    drive_cycle(1'b1, 8'h54, 8'hAC, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'hE4, 8'h1C, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'h1C, 8'h54, 1'b0, 1'b0);
    n_checks++; if (obs_rdy !== 1'b0 || obs_vld !== 1'b1)
      $display("FAIL full_ready got rdy %b vld %b want 0 1", obs_rdy, obs_vld); else n_pass++;
    @(negedge clk);
    in_vld = 1'b0; out_rdy = 1'b1;
    rst = 1'b1;
    #1;
    n_checks++; if (out_vld !== 1'b0) $display("FAIL rst_mid_valid got %b want 0", out_vld); else n_pass++;
    n_checks++; if (cnt_bus !== 8'h00) $display("FAIL rst_mid_cnt got %h want 00", cnt_bus); else n_pass++;
    n_checks++; if (sym !== 4'h0) $display("FAIL rst_mid_sym got %h want 0", sym); else n_pass++;
    exp_q.delete();
    mcnt[0] = 0; mcnt[1] = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive_cycle(c == 0, 8'hE4, 8'h54, 1'b1, 1'b0);
      n_checks++;
      if (obs_vld !== (c == 2)) $display("FAIL rst_first_beat cycle %0d got %b want %b", c, obs_vld, (c == 2));
      else n_pass++;
      if (obs_xfer) begin
        n_checks++;
        if ({obs_flag, obs_sym} !== exp_beat)
          $display("FAIL rst_first_data got %h want %h", {obs_flag, obs_sym}, exp_beat);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    logic v;
    thr_lo  = 8'(-56 + int'($urandom_range(16)) - 8);
    thr_mid = 8'(int'($urandom_range(16)) - 8);
    thr_hi  = 8'(56 + int'($urandom_range(16)) - 8);
    a = 8'($urandom); b = 8'($urandom); v = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (c == 150) begin
        thr_lo = 8'hD0; thr_mid = 8'h04; thr_hi = 8'h30;
      end
      if (!v || obs_acc) begin
        v = ($urandom_range(3) != 0) && (c < 280);
        a = 8'($urandom); b = 8'($urandom);
      end
      drive_cycle(v, a, b, $urandom_range(9) < 7, $urandom_range(63) == 0);
      if (obs_xfer) begin
        n_checks++;
        if ({obs_flag, obs_sym} !== exp_beat)
          $display("FAIL rand_data cycle %0d got %h want %h", c, {obs_flag, obs_sym}, exp_beat);
        else n_pass++;
      end
      n_checks++;
      if (obs_cnt !== {4'(mcnt[1]), 4'(mcnt[0])})
        $display("FAIL rand_cnt cycle %0d got %h want %h", c, obs_cnt, {4'(mcnt[1]), 4'(mcnt[0])});
      else n_pass++;
    end
    for (int c = 0; c < 10; c++) drive_cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    n_checks++; if (exp_q.size() != 0) $display("FAIL rand_drain got %0d pending want 0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_boundary();
    test_back_to_back();
    test_counter();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
